// File: rtl/apb_slave_regs.sv
// rtl/apb_slave_regs.sv - APB completer with a word-addressed register file and read-only STATUS counter
// Optional wait states are built only when APB_SLV_WAIT_EN is defined.
module apb_slave_regs #(
   parameter int NREGS       = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [31:0]              PADDR,
   input  logic                     PWRITE,
   input  logic [31:0]              PWDATA,
   input  logic                     PSELx,
   input  logic                     PENABLE,
   output logic [31:0]              PRDATA,
   output logic                     PREADY,
   output logic                     PSLVERR,
   output logic [31:0]              o_ctrl,
   output logic                     o_wr_pulse,
   output logic [$clog2(NREGS)-1:0] o_wr_idx
);

   localparam int IW = $clog2(NREGS);
   localparam logic [IW-1:0] STATUS_IDX = IW'(NREGS - 1);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t        state;
   logic [31:0]   regs [NREGS];
   logic [IW-1:0] idx_q;
   logic          write_q;
   logic          err_q;
   logic [31:0]   wdata_q;

   logic [IW-1:0] dec_idx;
   logic          dec_err;
   logic [IW-1:0] ld_idx;
   logic          ld_err;
   logic [31:0]   ld_data;

`ifdef APB_SLV_WAIT_EN
   logic [3:0]    cnt;
`endif

   assign dec_idx = PADDR[IW+1:2];
   assign dec_err = (PADDR[1:0] != 2'b00) || (PADDR[31:IW+2] != '0) ||
                    (PWRITE && (dec_idx == STATUS_IDX));

   // On the setup edge the response may load at once, so decode straight from the bus there.
   always_comb begin
      ld_idx = idx_q;
      ld_err = err_q;
      if (state == IDLE) begin
         ld_idx = dec_idx;
         ld_err = dec_err;
      end
   end

   assign ld_data = regs[ld_idx];
   assign o_ctrl  = regs[0];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= IDLE;
         PREADY     <= 1'b0;
         PRDATA     <= '0;
         PSLVERR    <= 1'b0;
         o_wr_pulse <= 1'b0;
         o_wr_idx   <= '0;
         idx_q      <= '0;
         write_q    <= 1'b0;
         err_q      <= 1'b0;
         wdata_q    <= '0;
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
`ifdef APB_SLV_WAIT_EN
         cnt        <= '0;
`endif
      end else begin
         o_wr_pulse <= 1'b0;
         case (state)
            IDLE: begin
               if (PSELx && !PENABLE) begin
                  state   <= ACCESS;
                  idx_q   <= dec_idx;
                  write_q <= PWRITE;
                  err_q   <= dec_err;
                  wdata_q <= PWDATA;
`ifdef APB_SLV_WAIT_EN
                  cnt     <= 4'(WAIT_CYCLES);
                  if (WAIT_CYCLES == 0) begin
                     PREADY  <= 1'b1;
                     PSLVERR <= ld_err;
                     PRDATA  <= ld_err ? 32'd0 : ld_data;
                  end
`else
                  PREADY  <= 1'b1;
                  PSLVERR <= ld_err;
                  PRDATA  <= ld_err ? 32'd0 : ld_data;
`endif
               end
            end
            ACCESS: begin
               if (!PSELx) begin
                  state   <= IDLE;
                  PREADY  <= 1'b0;
                  PRDATA  <= '0;
                  PSLVERR <= 1'b0;
               end else if (PENABLE) begin
                  if (PREADY) begin
                     if (write_q && !err_q) begin
                        regs[idx_q] <= wdata_q;
                        o_wr_pulse  <= 1'b1;
                        o_wr_idx    <= idx_q;
                     end
                     if (!err_q) regs[NREGS-1] <= regs[NREGS-1] + 32'd1;
                     state   <= IDLE;
                     PREADY  <= 1'b0;
                     PRDATA  <= '0;
                     PSLVERR <= 1'b0;
                  end
`ifdef APB_SLV_WAIT_EN
                  else begin
                     if (cnt <= 4'd1) begin
                        PREADY  <= 1'b1;
                        PSLVERR <= ld_err;
                        PRDATA  <= ld_err ? 32'd0 : ld_data;
                     end
                     if (cnt != 4'd0) cnt <= cnt - 4'd1;
                  end
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/apb_slave_regs.md
# apb_slave_regs

APB completer (slave) exposing a small word-addressed register file to an APB requester. It decodes PADDR, performs reads and writes and inserts optional wait states via PREADY. Illegal accesses are flagged with PSLVERR. It sits on the peripheral side of the APB bus, opposite the team's apb_master, and is the standard endpoint for that master in simulation and formal benches.

## Interface
- NREGS, 8: number of 32-bit registers; power of two, at least 2.
- WAIT_CYCLES, 2: wait states inserted per transfer; 0..15; only used when APB_SLV_WAIT_EN is defined.
- clk  in  1  clock; all logic on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- PADDR  in  32  byte address.
- PWRITE  in  1  1 = write, 0 = read.
- PWDATA  in  32  write data.
- PSELx  in  1  completer select.
- PENABLE  in  1  access phase.
- PRDATA  out  32  read data; valid only while PREADY=1.
- PREADY  out  1  transfer completion; registered.
- PSLVERR  out  1  error response; valid only while PREADY=1.
- o_ctrl  out  32  live value of register 0.
- o_wr_pulse  out  1  one-cycle pulse after each committed write.
- o_wr_idx  out  log2(NREGS)  index of the last committed write.

## Operation
- Register map:
  - idx = PADDR[log2(NREGS)+1:2].
  - Registers 0..NREGS-2 are read/write.
  - Register NREGS-1 is read-only STATUS: a 32-bit count of transfers completed with PSLVERR=0. It wraps at 2^32.
- Error conditions, each giving PSLVERR=1:
  - PADDR[1:0] != 0.
  - PADDR[31:log2(NREGS)+2] != 0.
  - A write to STATUS.
  - On error, no register changes and PRDATA=0.
- FSM states: IDLE, ACCESS.
  - IDLE to ACCESS: the sampled edge has PSELx=1 and PENABLE=0 (setup phase). On that edge, latch the address decode, PWRITE and PWDATA. Load the wait counter with WAIT_CYCLES.
  - ACCESS with PREADY=0 and PSELx&PENABLE: decrement the counter.
  - ACCESS with PREADY=1 and PSELx&PENABLE: completion edge. Commit any write, increment STATUS if there is no error, drop PREADY and go to IDLE.
  - ACCESS with PSELx=0 (aborted transfer): go to IDLE. No write, no STATUS change, PREADY=0.
- PREADY, PRDATA and PSLVERR load together on the edge that makes PREADY=1.
  - Read data is the register value at that edge.
  - Reads of STATUS return the count before the current transfer.
- Write commit:
  - The register updates at the completion edge.
  - o_wr_pulse=1 and o_wr_idx=idx in the following cycle.
  - A write that errors does not pulse.
- Outside PREADY=1, PRDATA=0 and PSLVERR=0.

## Timing
- Setup phase in cycle T means PSELx=1 and PENABLE=0 during T. The first access cycle is T+1.
- PREADY is high during cycle T+1+N only, where N is the effective wait count.
- Back-to-back transfers: a new setup in the cycle right after completion is accepted. Sustained throughput is one transfer per N+2 cycles.
- Reset values, all zero: PRDATA, PREADY, PSLVERR, o_ctrl, o_wr_pulse, o_wr_idx, all registers, STATUS. FSM resets to IDLE.
- Reset asserted mid-transfer: all outputs and state return to reset values on that edge. No write commits.
- The write port and STATUS increment are never active in the same cycle for the same register, since STATUS is read-only.

## Configuration
- APB_SLV_WAIT_EN defined:
  - The wait counter is built.
  - N = WAIT_CYCLES.
  - The counter is 4 bits and saturates at 0.
- APB_SLV_WAIT_EN undefined:
  - No counter logic is built; WAIT_CYCLES is ignored.
  - N = 0: PREADY rises on the setup edge and every transfer completes in its first access cycle.

## Test plan
- Reset, then write 0xDEADBEEF to 0x0 with WAIT_CYCLES=2 and the macro defined -> PREADY high only in cycle T+3 with PSLVERR=0. o_ctrl=0xDEADBEEF from T+4. o_wr_pulse=1 and o_wr_idx=0 in T+4.
- Write 0x12345678 to 0x8, then read 0x8 -> PRDATA=0x12345678 with PREADY=1 and PSLVERR=0. Read STATUS at 0x1C -> 2.
- Write to 0x1C, then to 0x2, then read 0x40 -> each returns PSLVERR=1 and PRDATA=0, with no register change and no o_wr_pulse. STATUS is unchanged.
- Macro undefined: back-to-back write 0x0 then read 0x0 -> each PREADY high in the first access cycle. The read returns the new data; 2 cycles per transfer.
- PSELx dropped during a wait state of a write to 0x4 -> no PREADY, register 0x4 unchanged, FSM back in IDLE. The next transfer completes normally.
- reset_n low during ACCESS of a write -> all outputs 0 next cycle and the target register keeps its old value.
